keccak_padder_mr: RTL

Multi-rate input buffer and padder for the high-throughput Keccak core. Packs 64-bit message words into one rate-sized block and applies Keccak multi-rate padding (pad10*1). The rate is chosen at run time per message: 1152, 1088, 832 or 576 bits, for the 224/256/384/512 digest widths. Completed blocks go to the permutation stage through an out_ready/f_ack handshake; this replaces the fixed 576-bit padder.

---
 rtl/keccak_padder_mr.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/keccak_padder_mr.sv
// keccak_padder_mr: packs 64-bit words into one rate-sized block and applies pad10*1.
// Build option: define SHA3_FIPS_PAD_EN to use the SHA-3 domain pad byte 0x06 instead of 0x01.
module keccak_padder_mr #(
    parameter int MAX_WORDS = 18,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [63:0]             in,
    input  logic                    in_ready,
    input  logic                    is_last,
    input  logic [2:0]              byte_num,
    output logic                    buffer_full,
    output logic [64*MAX_WORDS-1:0] out,
    output logic                    out_ready,
    input  logic                    f_ack
);

    // state     | meaning
    // ACCEPT    | collecting message words into the block
    // FULL      | data block complete, waiting for f_ack
    // LAST_FULL | padded final block complete, waiting for f_ack
    // DONE      | message finished, inputs ignored until reset
    typedef enum logic [1:0] {
        ACCEPT    = 2'd0,
        FULL      = 2'd1,
        LAST_FULL = 2'd2,
        DONE      = 2'd3
    } state_t;

`ifdef SHA3_FIPS_PAD_EN
    localparam logic [7:0] PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

    function automatic logic [CNT_W-1:0] rate_of(input logic [1:0] m);
        logic [CNT_W-1:0] r;
        case (m)
            2'd0:    r = CNT_W'(18);
            2'd1:    r = CNT_W'(17);
            2'd2:    r = CNT_W'(13);
            default: r = CNT_W'(9);
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             started_q, started_d;
    logic [63:0]      buf_q [MAX_WORDS];
    logic [63:0]      buf_d [MAX_WORDS];
    logic [CNT_W-1:0] rate_cur;
    logic [63:0]      pad_word;
    logic             take_word;
    logic             take_last;

    // The rate is frozen once the message has started, so mid-message mode changes are ignored.
    always_comb begin
        rate_cur  = started_q ? rate_q : rate_of(mode);
        take_word = in_ready && !is_last && (state_q == ACCEPT);
        take_last = in_ready &&  is_last && (state_q == ACCEPT);
    end

    always_comb begin
        pad_word = '0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < byte_num)
                pad_word[63-8*i -: 8] = in[63-8*i -: 8];
            else if (3'(i) == byte_num)
                pad_word[63-8*i -: 8] = PAD_BYTE;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        started_d = started_q;
        for (int j = 0; j < MAX_WORDS; j++)
            buf_d[j] = buf_q[j];

        case (state_q)
            ACCEPT: begin
                if (take_word) begin
                    for (int j = 0; j < MAX_WORDS; j++)
                        if (CNT_W'(j) == cnt_q)
                            buf_d[j] = in;
                    cnt_d     = cnt_q + 1'b1;
                    rate_d    = rate_cur;
                    started_d = 1'b1;
                    if (cnt_q + 1'b1 == rate_cur)
                        state_d = FULL;
                end else if (take_last) begin
                    rate_d    = rate_cur;
                    started_d = 1'b1;
                    // Final slot, zero-fill and the closing 0x80 all land in this one edge.
                    for (int j = 0; j < MAX_WORDS; j++) begin
                        if (CNT_W'(j) == cnt_q)
                            buf_d[j] = pad_word;
                        else if (CNT_W'(j) > cnt_q)
                            buf_d[j] = '0;
                        if (CNT_W'(j) == rate_cur - 1'b1)
                            buf_d[j][7:0] = buf_d[j][7:0] | 8'h80;
                    end
                    state_d = LAST_FULL;
                end
            end
            FULL: begin
                if (f_ack) begin
                    state_d = ACCEPT;
                    cnt_d   = '0;
                    for (int j = 0; j < MAX_WORDS; j++)
                        buf_d[j] = '0;
                end
            end
            LAST_FULL: begin
                if (f_ack)
                    state_d = DONE;
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCEPT;
            cnt_q       <= '0;
            rate_q      <= '0;
            started_q   <= 1'b0;
            out_ready   <= 1'b0;
            buffer_full <= 1'b0;
            for (int j = 0; j < MAX_WORDS; j++)
                buf_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rate_q      <= rate_d;
            started_q   <= started_d;
            out_ready   <= (state_d == FULL) || (state_d == LAST_FULL);
            buffer_full <= (state_d == FULL) || (state_d == LAST_FULL);
            for (int j = 0; j < MAX_WORDS; j++)
                buf_q[j] <= buf_d[j];
        end
    end

    always_comb begin
        out = '0;
        for (int j = 0; j < MAX_WORDS; j++)
            out[64*(MAX_WORDS-1-j) +: 64] = buf_q[j];
    end

endmodule
